// File: rtl/dpwm_frame_gen_if.sv
// Duty-command handshake bundle between the duty source and the DPWM frame generator.
interface dpwm_frame_gen_if #(
    parameter int Dc_length = 13
) ();
    logic [Dc_length-1:0] dc_in;
    logic                 dc_valid;
    logic                 dc_ready;

    modport master (output dc_in, output dc_valid, input dc_ready);
    modport slave  (input dc_in, input dc_valid, output dc_ready);
endinterface

// File: rtl/dpwm_frame_gen.sv
// DPWM frame generator: coarse frame counter, L_DPWM marker, double-buffered duty word
// and coarse PWM comparator against the edge counter's half-cycle count.
module dpwm_frame_gen #(
    parameter int DE_bits      = 6,
    parameter int Dc_length    = 13,
    parameter int Count_length = Dc_length - DE_bits
) (
    input  logic                    clk_base,
    input  logic                    reset_Flags,
    input  logic                    en,
    dpwm_frame_gen_if.slave         dc_bus,
    input  logic [Count_length+2:0] flags_in,
    output logic                    L_DPWM,
    output logic                    frame_start,
    output logic                    pwm_out,
    output logic [DE_bits-2:0]      dc_fine
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [Count_length-1:0] FC_LAST = '1;
    // 2P-2: all ones above bit 0
    localparam logic [Count_length:0]   THR_MAX = {{Count_length{1'b1}}, 1'b0};

    logic [1:0]              state, state_nxt;
    logic [Count_length-1:0] fc, fc_nxt;
    logic                    shadow_full;
    logic [Dc_length-1:0]    shadow, dc_active, dc_eff;
    logic                    hs, xfer;
    logic [Count_length:0]   thr_raw, thr;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = (fc == FC_LAST) ? IDLE : DRAIN;
            DRAIN: begin
                if (en)                 state_nxt = RUN;
                else if (fc == FC_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Wraps to 0 after P-1, which is also where any exit to IDLE happens.
        fc_nxt = (state == IDLE) ? '0 : fc + 1'b1;
    end

    assign dc_bus.dc_ready = !shadow_full;
    assign hs              = dc_bus.dc_valid && !shadow_full;
    assign xfer            = frame_start && shadow_full;

    // The new duty is already in effect during the frame_start cycle itself.
    assign dc_eff  = xfer ? shadow : dc_active;
    assign dc_fine = dc_eff[DE_bits-2:0];
    assign thr_raw = dc_eff[Dc_length-1:DE_bits-1];
    assign thr     = (thr_raw > THR_MAX) ? THR_MAX : thr_raw;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_base or posedge reset_Flags) begin
        if (reset_Flags) begin
            state       <= IDLE;
            fc          <= '0;
            L_DPWM      <= 1'b0;
            frame_start <= 1'b0;
            pwm_out     <= 1'b0;
            shadow_full <= 1'b0;
            // NOTE: the duty data registers are reset too, so dc_fine and thr are
            // defined from the first cycle rather than waiting for a first load.
            shadow      <= '0;
            dc_active   <= '0;
        end else begin
            state       <= state_nxt;
            fc          <= fc_nxt;
            L_DPWM      <= (state_nxt != IDLE) && (fc_nxt != FC_LAST);
            frame_start <= (state_nxt == RUN) && (fc_nxt == '0);
            pwm_out     <= (state != IDLE) && L_DPWM && (flags_in < {2'b00, thr});

            // Full and empty are exclusive, so a load and a transfer never collide.
            if (xfer) begin
                dc_active   <= shadow;
                shadow_full <= 1'b0;
            end else if (hs) begin
                shadow      <= dc_bus.dc_in;
                shadow_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpwm_frame_gen.sv
// Directed bench for dpwm_frame_gen at default parameters (P = 128 cycles per frame).
module tb_dpwm_frame_gen;

    logic       clk_base = 1'b0;
    logic       reset_Flags;
    logic       en;
    logic [9:0] flags_in;
    logic       L_DPWM, frame_start, pwm_out;
    logic [4:0] dc_fine;

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_full;
    logic        exp_pwm_next;
    logic [12:0] pend[$];

    dpwm_frame_gen_if #(.Dc_length(13)) dc_bus ();

    dpwm_frame_gen dut (
        .clk_base   (clk_base),
        .reset_Flags(reset_Flags),
        .en         (en),
        .dc_bus     (dc_bus),
        .flags_in   (flags_in),
        .L_DPWM     (L_DPWM),
        .frame_start(frame_start),
        .pwm_out    (pwm_out),
        .dc_fine    (dc_fine)
    );

    always #5 clk_base = ~clk_base;

    task automatic tick();
        @(posedge clk_base);
        #1;
    endtask

    task automatic do_reset();
        reset_Flags     = 1'b1;
        en              = 1'b0;
        dc_bus.dc_valid = 1'b0;
        dc_bus.dc_in    = '0;
        flags_in        = '0;
        pend.delete();
        exp_full        = 1'b0;
        exp_pwm_next    = 1'b0;
        tick();
        tick();
        reset_Flags = 1'b0;
    endtask

    // One-cycle handshake while idle; the shadow must report full afterwards.
    task automatic idle_load(input logic [12:0] val);
        n_vec++;
        if (dc_bus.dc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_load_ready_before got %b want 1", dc_bus.dc_ready);
        end
        dc_bus.dc_valid = 1'b1;
        dc_bus.dc_in    = val;
        tick();
        dc_bus.dc_valid = 1'b0;
        exp_full        = 1'b1;
        n_vec++;
        if (dc_bus.dc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_load_ready_after got %b want 0", dc_bus.dc_ready);
        end
    endtask

    // Plays one full frame starting with the DUT at fc=0; flags_in = k + off.
    task automatic play_frame(input int off, input int thr, input int load_k,
                              input logic [12:0] load_val, input int drop_k, input int rise_k);
        for (int k = 0; k < 128; k++) begin
            logic hs;
            n_vec++;
            if (L_DPWM !== (k != 127)) begin
                n_err++;
                $display("FAIL frame_l_dpwm k=%0d got %b want %b", k, L_DPWM, (k != 127));
            end
            n_vec++;
            if (frame_start !== (k == 0)) begin
                n_err++;
                $display("FAIL frame_start k=%0d got %b want %b", k, frame_start, (k == 0));
            end
            n_vec++;
            if (pwm_out !== exp_pwm_next) begin
                n_err++;
                $display("FAIL frame_pwm k=%0d thr=%0d got %b want %b", k, thr, pwm_out, exp_pwm_next);
            end
            n_vec++;
            if (dc_bus.dc_ready !== !exp_full) begin
                n_err++;
                $display("FAIL frame_ready k=%0d got %b want %b", k, dc_bus.dc_ready, !exp_full);
            end

            if (k == load_k) pend.push_back(load_val);
            if (k == drop_k) en = 1'b0;
            if (k == rise_k) en = 1'b1;
            hs              = (pend.size() > 0) && !exp_full;
            dc_bus.dc_valid = (pend.size() > 0);
            if (pend.size() > 0) dc_bus.dc_in = pend[0];
            flags_in        = 10'(k + off);
            exp_pwm_next    = (k != 127) && ((k + off) < thr);
            tick();
            if (k == 0 && exp_full) exp_full = 1'b0;
            if (hs) begin
                void'(pend.pop_front());
                exp_full = 1'b1;
            end
        end
        dc_bus.dc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_Flags = 1'b1;
        en          = 1'b0;
        #2;
        n_vec++;
        if ({L_DPWM, frame_start, pwm_out, dc_bus.dc_ready, dc_fine} !== 9'b000_1_00000) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 000100000",
                     {L_DPWM, frame_start, pwm_out, dc_bus.dc_ready, dc_fine});
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({L_DPWM, frame_start, pwm_out, dc_bus.dc_ready} !== 4'b0001) begin
                n_err++;
                $display("FAIL idle_outputs cyc=%0d got %b want 0001", i,
                         {L_DPWM, frame_start, pwm_out, dc_bus.dc_ready});
            end
        end
    endtask

    task automatic test_no_duty();
        do_reset();
        en = 1'b1;
        tick();
        play_frame(0, 0, -1, '0, -1, -1);
        play_frame(0, 0, -1, '0, -1, -1);
    endtask

    task automatic test_preload();
        do_reset();
        idle_load(13'h0A40);
        en = 1'b1;
        tick();
        play_frame(0, 82, -1, '0, -1, -1);
        play_frame(0, 82, -1, '0, -1, -1);
    endtask

    task automatic test_midframe();
        do_reset();
        en = 1'b1;
        tick();
        play_frame(0, 0, 50, 13'h0A40, -1, -1);
        play_frame(0, 82, -1, '0, -1, -1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        pend.push_back(13'h0A40);
        pend.push_back(13'h0400);
        pend.push_back(13'h1FFF);
        en              = 1'b1;
        dc_bus.dc_valid = 1'b1;
        dc_bus.dc_in    = pend[0];
        tick();
        void'(pend.pop_front());
        exp_full = 1'b1;
        play_frame(0, 82, -1, '0, -1, -1);
        play_frame(0, 32, -1, '0, -1, -1);
        // Clamped threshold: flags 128..253 pass, 254 on k=126 does not.
        play_frame(128, 254, -1, '0, -1, -1);
        play_frame(0, 254, -1, '0, -1, -1);
        n_vec++;
        if (pend.size() != 0) begin
            n_err++;
            $display("FAIL b2b_all_accepted got %0d pending want 0", pend.size());
        end
        n_vec++;
        if (dc_fine !== 5'h1F) begin
            n_err++;
            $display("FAIL b2b_dc_fine got %h want 1f", dc_fine);
        end
    endtask

    task automatic test_drain();
        do_reset();
        idle_load(13'h0A40);
        en = 1'b1;
        tick();
        // Drop then re-raise: the frame continues and the next one starts normally.
        play_frame(0, 82, -1, '0, 40, 60);
        play_frame(0, 82, -1, '0, 40, -1);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({L_DPWM, frame_start, pwm_out, dc_bus.dc_ready} !== 4'b0001) begin
                n_err++;
                $display("FAIL drain_idle cyc=%0d got %b want 0001", i,
                         {L_DPWM, frame_start, pwm_out, dc_bus.dc_ready});
            end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        idle_load(13'h1FFF);
        en = 1'b1;
        tick();
        for (int i = 0; i < 60; i++) tick();
        n_vec++;
        if ({L_DPWM, pwm_out, dc_fine} !== 7'b11_11111) begin
            n_err++;
            $display("FAIL pre_reset_fc60 got %b want 1111111", {L_DPWM, pwm_out, dc_fine});
        end
        reset_Flags = 1'b1;
        #1;
        n_vec++;
        if ({L_DPWM, frame_start, pwm_out, dc_bus.dc_ready, dc_fine} !== 9'b000_1_00000) begin
            n_err++;
            $display("FAIL async_reset_fc60 got %b want 000100000",
                     {L_DPWM, frame_start, pwm_out, dc_bus.dc_ready, dc_fine});
        end
        en = 1'b0;
        tick();
        reset_Flags = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({L_DPWM, frame_start} !== 2'b00) begin
                n_err++;
                $display("FAIL post_reset_no_en cyc=%0d got %b want 00", i, {L_DPWM, frame_start});
            end
        end
        en = 1'b1;
        tick();
        n_vec++;
        if ({L_DPWM, frame_start, pwm_out, dc_fine} !== 8'b110_00000) begin
            n_err++;
            $display("FAIL post_reset_first_frame got %b want 11000000",
                     {L_DPWM, frame_start, pwm_out, dc_fine});
        end
    endtask

    initial begin
        test_reset();
        test_no_duty();
        test_preload();
        test_midframe();
        test_back_to_back();
        test_drain();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
